// File: rtl/neuron_pkg.sv
// Shared types and saturation helper for the neuron datapath blocks.
package neuron_pkg;

  typedef enum logic [1:0] {
    ACT_LINEAR = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_LEAKY  = 2'b10,
    ACT_CLIP   = 2'b11
  } act_mode_e;

  typedef enum logic [1:0] {IDLE, BUSY, ACT, DONE} state_e;

  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] value,
                                                         input int width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/neuron_lane_mac.sv
// One beat of the neuron dot product: LANES signed multiplies summed; lanes past the last input read zero.
module neuron_lane_mac #(
  parameter int DATA_WIDTH   = 8,
  parameter int NEURON_BITS  = 8,
  parameter int NEURON_WIDTH = 4,
  parameter int LANES        = 2,
  parameter int BEATS        = 2,
  parameter int BEAT_W       = 1,
  parameter int ACC_W        = 20
) (
  input  logic [NEURON_WIDTH-1:0][DATA_WIDTH-1:0]  w,
  input  logic [NEURON_WIDTH-1:0][NEURON_BITS-1:0] x,
  input  logic [BEAT_W-1:0]                        beat,
  output logic signed [ACC_W-1:0]                  beat_sum
);

  logic [BEATS-1:0][LANES-1:0][DATA_WIDTH-1:0]  w_pad;
  logic [BEATS-1:0][LANES-1:0][NEURON_BITS-1:0] x_pad;

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      if (b * LANES + l < NEURON_WIDTH) begin : g_live
        assign w_pad[b][l] = w[b*LANES+l];
        assign x_pad[b][l] = x[b*LANES+l];
      end else begin : g_pad
        assign w_pad[b][l] = '0;
        assign x_pad[b][l] = '0;
      end
    end
  end

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + ACC_W'($signed(w_pad[beat][l])) * ACC_W'($signed(x_pad[beat][l]));
    end
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: act(bias + sum w*x) over BEATS cycles, result after BEATS+1 cycles.
// Single operand set in flight; in_ready only in IDLE, result held until out_ready.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NEURON_BITS  = 8,
  parameter int NEURON_WIDTH = 4,
  parameter int LANES        = 2,
  parameter int B_BITS       = 16,
  parameter int OUT_BITS     = 16,
  parameter int CLIP_MAX     = 127
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [1:0]                               act_mode,
  input  logic [NEURON_WIDTH-1:0][DATA_WIDTH-1:0]  weights,
  input  logic [NEURON_WIDTH-1:0][NEURON_BITS-1:0] data_in,
  input  logic signed [B_BITS-1:0]                 bias,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [OUT_BITS-1:0]               neuron_out,
  output logic                                     sat_flag
);

  localparam int BEATS  = (NEURON_WIDTH + LANES - 1) / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PROD_W = DATA_WIDTH + NEURON_BITS + $clog2(NEURON_WIDTH + 1);
  localparam int ACC_W  = ((PROD_W > B_BITS) ? PROD_W : B_BITS) + 1;
  localparam logic signed [ACC_W-1:0] CLIP_LIM = ACC_W'(CLIP_MAX);

  state_e                                   state_q, state_d;
  logic [BEAT_W-1:0]                        beat_q, beat_d;
  logic signed [ACC_W-1:0]                  acc_q, acc_d;
  logic [NEURON_WIDTH-1:0][DATA_WIDTH-1:0]  w_q, w_d;
  logic [NEURON_WIDTH-1:0][NEURON_BITS-1:0] x_q, x_d;
  act_mode_e                                mode_q, mode_d;
  logic                                     out_valid_q, out_valid_d;
  logic signed [OUT_BITS-1:0]               neuron_out_q, neuron_out_d;
  logic                                     sat_q, sat_d;

  logic signed [ACC_W-1:0] beat_sum;
  logic signed [ACC_W-1:0] act_val;
  logic signed [SAT_W-1:0] act_ext;
  logic signed [SAT_W-1:0] clamped;

  neuron_lane_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NEURON_BITS (NEURON_BITS),
    .NEURON_WIDTH(NEURON_WIDTH),
    .LANES       (LANES),
    .BEATS       (BEATS),
    .BEAT_W      (BEAT_W),
    .ACC_W       (ACC_W)
  ) u_lane_mac (
    .w       (w_q),
    .x       (x_q),
    .beat    (beat_q),
    .beat_sum(beat_sum)
  );

  // Activation first, then the OUT_BITS clamp; only the latter raises sat_flag.
  always_comb begin
    act_val = acc_q;
    unique case (mode_q)
      ACT_RELU:  if (acc_q < 0) act_val = '0;
      ACT_LEAKY: if (acc_q < 0) act_val = acc_q >>> 3;
      ACT_CLIP: begin
        if (acc_q < 0) act_val = '0;
        else if (acc_q > CLIP_LIM) act_val = CLIP_LIM;
      end
      default: act_val = acc_q;
    endcase
    act_ext = SAT_W'(act_val);
    clamped = sat_signed(act_ext, OUT_BITS);
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    acc_d        = acc_q;
    w_d          = w_q;
    x_d          = x_q;
    mode_d       = mode_q;
    out_valid_d  = out_valid_q;
    neuron_out_d = neuron_out_q;
    sat_d        = sat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          w_d     = weights;
          x_d     = data_in;
          mode_d  = act_mode_e'(act_mode);
          acc_d   = ACC_W'(bias);
          beat_d  = '0;
        end
      end
      BUSY: begin
        acc_d = acc_q + beat_sum;
        if (beat_q == BEAT_W'(BEATS - 1)) state_d = ACT;
        else beat_d = beat_q + BEAT_W'(1);
      end
      ACT: begin
        neuron_out_d = OUT_BITS'(clamped);
        sat_d        = (clamped != act_ext);
        out_valid_d  = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      acc_q        <= '0;
      w_q          <= '0;
      x_q          <= '0;
      mode_q       <= ACT_LINEAR;
      out_valid_q  <= 1'b0;
      neuron_out_q <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      acc_q        <= acc_d;
      w_q          <= w_d;
      x_q          <= x_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      neuron_out_q <= neuron_out_d;
      sat_q        <= sat_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign neuron_out = neuron_out_q;
  assign sat_flag   = sat_q;

endmodule
